// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave SRAM with FIXED/INCR/WRAP bursts, byte strobes and OKAY/SLVERR responses.
module axi_sram_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);
  localparam int LB = $clog2(DATA_W / 8);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  logic [DATA_W-1:0] mem [DEPTH];
  function automatic logic berr(input logic [2:0] s, input logic [7:0] l, input logic [1:0] b);
    return s > 3'(LB) || b == 2'd3 || (b == 2'd2 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction
  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return (a >> LB) >= ADDR_W'(DEPTH);
  endfunction
  function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a, input logic [2:0] s,
                                            input logic [7:0] l, input logic [1:0] b);
    logic [ADDR_W-1:0] bs, ws, inc;
    bs  = ADDR_W'(1) << s;
    ws  = bs * (ADDR_W'(l) + ADDR_W'(1));
    inc = (a & ~(bs - ADDR_W'(1))) + bs;
    return b == 2'd0 ? a : b == 2'd2 ? (a & ~(ws - ADDR_W'(1))) | (inc & (ws - ADDR_W'(1))) : inc;
  endfunction
  w_state_e w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0] w_len_q, w_cnt_q;
  logic [2:0] w_size_q;
  logic [1:0] w_burst_q, bresp_q;
  logic [ID_W-1:0] bid_q;
  logic w_berr_q, w_err_q, aw_hs, w_hs, w_last, w_beat_err;
  assign awready    = w_state_q == W_IDLE;
  assign wready     = w_state_q == W_DATA;
  assign bvalid     = w_state_q == W_RESP;
  assign bid        = bid_q;
  assign bresp      = bresp_q;
  assign aw_hs      = awready & awvalid;
  assign w_hs       = wready & wvalid;
  assign w_last     = w_cnt_q == w_len_q;
  // wlast is only checked: a misplaced or missing wlast poisons that beat, awlen still ends the burst
  assign w_beat_err = w_berr_q | oor(w_addr_q) | (wlast != w_last);
  always_comb begin
    w_state_d = w_state_q;
    if (aw_hs) w_state_d = W_DATA;
    if (w_hs && w_last) w_state_d = W_RESP;
    if (bvalid && bready) w_state_d = W_IDLE;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_berr_q  <= 1'b0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_addr_q  <= awaddr;
        w_len_q   <= awlen;
        w_size_q  <= awsize;
        w_burst_q <= awburst;
        w_berr_q  <= berr(awsize, awlen, awburst);
        w_err_q   <= 1'b0;
        w_cnt_q   <= '0;
        bid_q     <= awid;
      end
      if (w_hs) begin
        w_addr_q <= nxt(w_addr_q, w_size_q, w_len_q, w_burst_q);
        w_cnt_q  <= w_cnt_q + 8'd1;
        w_err_q  <= w_err_q | w_beat_err;
        if (w_last) bresp_q <= (w_err_q | w_beat_err) ? 2'b10 : 2'b00;
      end
    end
  end
  always_ff @(posedge aclk) begin
    if (w_hs && !w_beat_err)
      for (int i = 0; i < DATA_W / 8; i++)
        if (wstrb[i]) mem[w_addr_q[LB +: IW]][8*i +: 8] <= wdata[8*i +: 8];
  end
  r_state_e r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q, la;
  logic [7:0] r_len_q, r_cnt_q, ll;
  logic [2:0] r_size_q, ls;
  logic [1:0] r_burst_q, lb, rresp_q;
  logic [ID_W-1:0] rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic r_berr_q, rlast_q, ar_hs, r_hs, ld, lerr;
  assign arready = r_state_q == R_IDLE;
  assign rvalid  = r_state_q == R_DATA;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign ar_hs   = arready & arvalid;
  assign r_hs    = rvalid & rready;
  // the output register is loaded at AR handshake and at each non-final beat handshake
  assign ld      = ar_hs | (r_hs & ~rlast_q);
  assign la      = ar_hs ? araddr : r_addr_q;
  assign ls      = ar_hs ? arsize : r_size_q;
  assign ll      = ar_hs ? arlen : r_len_q;
  assign lb      = ar_hs ? arburst : r_burst_q;
  assign lerr    = (ar_hs ? berr(arsize, arlen, arburst) : r_berr_q) | oor(la);
  always_comb begin
    r_state_d = r_state_q;
    if (ar_hs) r_state_d = R_DATA;
    if (r_hs && rlast_q) r_state_d = R_IDLE;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_berr_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ld) begin
        r_addr_q <= nxt(la, ls, ll, lb);
        rdata_q  <= lerr ? '0 : mem[la[LB +: IW]];
        rresp_q  <= lerr ? 2'b10 : 2'b00;
        if (ar_hs) begin
          r_len_q   <= arlen;
          r_size_q  <= arsize;
          r_burst_q <= arburst;
          r_berr_q  <= berr(arsize, arlen, arburst);
          rid_q     <= arid;
          rlast_q   <= arlen == 8'd0;
          r_cnt_q   <= 8'd1;
        end else begin
          rlast_q <= r_cnt_q == r_len_q;
          r_cnt_q <= r_cnt_q + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized and directed bench for axi_sram_slave against a burst-level memory model.
module tb_axi_sram_slave;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0] wstrb = '0;
  logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [31:0] m [DEPTH];
  logic [31:0] wd [256];
  logic [3:0] ws [256];
  int n_chk = 0, n_fail = 0;

  axi_sram_slave dut (
    .aclk(clk), .areset(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [2:0] s, input logic [7:0] l, input logic [1:0] b);
    return s > 3'd2 || b == 2'd3 || (b == 2'd2 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] s, input logic [7:0] l,
                                        input logic [1:0] b, input int i);
    longint unsigned bs, w, base, aa;
    aa = 64'(a);
    bs = 64'd1 << s;
    w  = bs * (64'(l) + 64'd1);
    if (b == 2'd0) return a;
    if (b == 2'd2) begin
      base = aa / w * w;
      return 32'(base + (aa - base + 64'(i) * bs) % w);
    end
    return i == 0 ? a : 32'(aa / bs * bs + 64'(i) * bs);
  endfunction

  task automatic wr(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bt, input int wlm, input int bst, input bit gaps);
    int t;
    logic [31:0] ba;
    logic [1:0] er;
    bit bad, e, any;
    bad = is_bad(sz, len, bt);
    any = 0;
    @(negedge clk);
    awvalid = 1; awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt;
    t = 0;
    while (!awready && t < 1000) begin @(negedge clk); t++; end
    chk("awready", 64'(awready), 1);
    @(negedge clk);
    awvalid = 0;
    chk("aw_drop", 64'(awready), 0);
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 0; @(negedge clk); end
      wvalid = 1; wdata = wd[i]; wstrb = ws[i];
      wlast = wlm == 1 ? 1'b0 : wlm == 2 ? (i == 0) : (i == int'(len));
      t = 0;
      while (!wready && t < 1000) begin @(negedge clk); t++; end
      chk("wready", 64'(wready), 1);
      ba = baddr(a, sz, len, bt, i);
      e = bad || ba / 4 >= DEPTH || (wlast != (i == int'(len)));
      if (!e)
        for (int b = 0; b < 4; b++) if (ws[i][b]) m[ba / 4][8*b +: 8] = wd[i][8*b +: 8];
      any |= e;
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    er = any ? 2'b10 : 2'b00;
    chk("bvalid", 64'(bvalid), 1);
    chk("bresp", 64'(bresp), 64'(er));
    chk("bid", 64'(bid), 64'(id));
    for (int k = 0; k < bst; k++) begin
      chk("b_hold", {bvalid, bresp, bid, awready}, {1'b1, er, id, 1'b0});
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("b_done", {bvalid, awready}, 2'b01);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bt, input bit stall);
    int t;
    logic [31:0] ba, ex;
    logic [38:0] sv;
    bit bad, e, held;
    bad = is_bad(sz, len, bt);
    held = 0;
    @(negedge clk);
    arvalid = 1; arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; rready = 0;
    t = 0;
    while (!arready && t < 1000) begin @(negedge clk); t++; end
    chk("arready", 64'(arready), 1);
    @(negedge clk);
    arvalid = 0;
    chk("ar_drop", 64'(arready), 0);
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) @(negedge clk);
      t = 0;
      while (1) begin
        rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (held) chk("r_stable", {rdata, rresp, rlast, rid}, sv);
        held = 0;
        if (rvalid && rready) break;
        if (rvalid) begin held = 1; sv = {rdata, rresp, rlast, rid}; end
        if (t == 1000) break;
        t++;
        @(negedge clk);
      end
      chk("rvalid", 64'(rvalid), 1);
      if (!stall) chk("r_gap", 64'(t), 0);
      ba = baddr(a, sz, len, bt, i);
      e = bad || ba / 4 >= DEPTH;
      ex = e ? 32'd0 : m[(ba / 4) % DEPTH];
      chk("rdata", 64'(rdata), 64'(ex));
      chk("rresp", 64'(rresp), e ? 64'd2 : 64'd0);
      chk("rlast", 64'(rlast), 64'(i == int'(len)));
      chk("rid", 64'(rid), 64'(id));
    end
    @(negedge clk);
    rready = 0;
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
  endtask

  initial begin
    logic [1:0] bt;
    logic [2:0] sz;
    logic [7:0] len;
    logic [31:0] a;
    int r;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", {awready, arready, wready}, 3'b110);
    chk("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    chk("rst_resp", {bresp, rresp, bid, rid}, 12'h000);
    chk("rst_rdata", 64'(rdata), 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr(4'(k), 32'(k * 1024), 8'd255, 3'd2, 2'd1, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    wr(4'h5, 32'h100, 8'd3, 3'd2, 2'd1, 0, 0, 0);
    rd(4'h6, 32'h100, 8'd3, 3'd2, 2'd1, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    wr(4'h1, 32'h10, 8'd3, 3'd2, 2'd1, 0, 0, 0);
    rd(4'h2, 32'h18, 8'd3, 3'd2, 2'd2, 0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    wr(4'h3, 32'h40, 8'd0, 3'd2, 2'd1, 0, 0, 0);
    wd[0] = 32'h12345678; ws[0] = 4'h5;
    wr(4'h3, 32'h40, 8'd0, 3'd2, 2'd1, 0, 0, 0);
    rd(4'h4, 32'h40, 8'd0, 3'd2, 2'd1, 0);
    chk("strobe_model", 64'(m[16]), 64'hFF34FF78);
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(4'h7, 32'h1000, 8'd0, 3'd2, 2'd1, 0, 0, 0);
    rd(4'h7, 32'h1000, 8'd0, 3'd2, 2'd1, 0);
    rd(4'h7, 32'h0, 8'd0, 3'd2, 2'd1, 0);
    fill(4);
    wr(4'h8, 32'h200, 8'd3, 3'd2, 2'd3, 0, 1, 0);
    wr(4'h8, 32'h200, 8'd1, 3'd3, 2'd1, 0, 1, 0);
    wr(4'h8, 32'h200, 8'd2, 3'd2, 2'd2, 0, 1, 0);
    wr(4'h9, 32'h210, 8'd3, 3'd2, 2'd1, 1, 0, 0);
    wr(4'h9, 32'h220, 8'd3, 3'd2, 2'd1, 2, 0, 0);
    rd(4'hA, 32'h200, 8'd15, 3'd2, 2'd1, 0);
    rd(4'hA, 32'h200, 8'd3, 3'd2, 2'd3, 0);
    rd(4'hA, 32'h200, 8'd1, 3'd3, 2'd1, 0);
    rd(4'hA, 32'hFF8, 8'd3, 3'd2, 2'd1, 0);
    fill(8);
    fork
      wr(4'hB, 32'h300, 8'd7, 3'd2, 2'd1, 0, 5, 0);
      rd(4'hC, 32'h380, 8'd7, 3'd2, 2'd1, 1);
    join
    rd(4'hD, 32'h300, 8'd7, 3'd2, 2'd1, 1);
    @(negedge clk);
    arvalid = 1; araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; rready = 0;
    awvalid = 1; awaddr = 32'h0; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1;
    @(negedge clk);
    arvalid = 0; awvalid = 0;
    wvalid = 1; wstrb = 4'h0; wlast = 0;
    @(negedge clk);
    wvalid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", {awready, arready, wready}, 3'b110);
    chk("abort_valid", {bvalid, rvalid, rlast}, 3'b000);
    rd(4'hE, 32'h0, 8'd3, 3'd2, 2'd1, 0);
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      bt = r < 4 ? 2'd1 : r < 6 ? 2'd2 : r < 8 ? 2'd0 : r == 8 ? 2'd3 : 2'd1;
      sz = $urandom_range(0, 9) == 0 ? 3'd3 : $urandom_range(0, 2) == 0 ? 3'($urandom_range(0, 1)) : 3'd2;
      r = $urandom_range(0, 4);
      len = bt == 2'd2 ? (r == 4 ? 8'd2 : 8'((2 << r) - 1)) : 8'($urandom_range(0, 15));
      if (bt == 2'd2 && len > 8'd15) len = 8'd15;
      a = 32'($urandom_range(0, 'h10FF)) & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        fill(int'(len) + 1);
        wr(4'($urandom), a, len, sz, bt, $urandom_range(0, 9) == 0 ? 1 : 0, $urandom_range(0, 3), 1);
      end else
        rd(4'($urandom), a, len, sz, bt, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
